// File: rtl/make_hint_stream.sv
// Signer-side ML-DSA hint generator: one hint bit per (a0, a1) coefficient, with hint count and OMEGA reject.
// Optional per-polynomial cumulative counts (pc_valid/pc_count) under MAKE_HINT_POLYCNT_EN.
module make_hint_stream #(
  parameter int unsigned GAMMA2 = 261888,
  parameter int unsigned N      = 256,
  parameter int unsigned K      = 6,
  parameter int unsigned OMEGA  = 55
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [31:0] s_a0,
  input  logic [3:0]         s_a1,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_hint,
  output logic [7:0]         m_idx,
  output logic [2:0]         m_poly,
  output logic               m_last,
  output logic               done,
  output logic [10:0]        hint_count,
  output logic               reject
`ifdef MAKE_HINT_POLYCNT_EN
  ,
  output logic               pc_valid,
  output logic [7:0]         pc_count
`endif
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned POLY_W = 3;
  localparam int unsigned CNT_W  = 11;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
  localparam logic [POLY_W-1:0] POLY_LAST = POLY_W'(K - 1);
  localparam logic [CNT_W-1:0]  OMEGA_C   = CNT_W'(OMEGA);
  localparam logic signed [31:0] G_POS    = 32'(GAMMA2);
  localparam logic signed [31:0] G_NEG    = -G_POS;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [POLY_W-1:0]   poly;
  logic                rej_en;
  logic                in_hs;
  logic                out_hs;
  logic                last_in;
  logic                hint_c;

  // Signed 32-bit threshold test on the centered low part
  assign hint_c = (s_a0 > G_POS) || (s_a0 < G_NEG) || ((s_a0 == G_NEG) && (s_a1 != 4'd0));

  assign s_ready = (state == RUN) && (!m_valid || m_ready);
  assign in_hs   = s_valid && s_ready;
  assign out_hs  = m_valid && m_ready;
  assign last_in = (idx == IDX_LAST) && (poly == POLY_LAST);

  // Reject becomes visible only once the vector has completed
  assign reject  = rej_en && (hint_count > OMEGA_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      poly       <= '0;
      m_valid    <= 1'b0;
      m_hint     <= 1'b0;
      m_idx      <= '0;
      m_poly     <= '0;
      m_last     <= 1'b0;
      done       <= 1'b0;
      hint_count <= '0;
      rej_en     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // New vector or abort; a coefficient offered this cycle is dropped
        state      <= RUN;
        idx        <= '0;
        poly       <= '0;
        m_valid    <= 1'b0;
        m_hint     <= 1'b0;
        m_idx      <= '0;
        m_poly     <= '0;
        m_last     <= 1'b0;
        hint_count <= '0;
        rej_en     <= 1'b0;
      end else begin
        if (in_hs) begin
          m_valid    <= 1'b1;
          m_hint     <= hint_c;
          m_idx      <= idx;
          m_poly     <= poly;
          m_last     <= last_in;
          hint_count <= hint_count + CNT_W'(hint_c);
          if (idx == IDX_LAST) begin
            idx  <= '0;
            poly <= poly + POLY_W'(1);
          end else begin
            idx <= idx + IDX_W'(1);
          end
          if (last_in) state <= FLUSH;
        end else if (out_hs) begin
          m_valid <= 1'b0;
        end
        if ((state == FLUSH) && out_hs && m_last) begin
          state  <= IDLE;
          done   <= 1'b1;
          rej_en <= 1'b1;
        end
      end
    end
  end

`ifdef MAKE_HINT_POLYCNT_EN
  // hint_count at the boundary handshake covers exactly the hints through that polynomial
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_valid <= 1'b0;
      pc_count <= '0;
    end else begin
      pc_valid <= 1'b0;
      if (!start && out_hs && (m_idx == IDX_LAST)) begin
        pc_valid <= 1'b1;
        pc_count <= (hint_count > CNT_W'(255)) ? 8'hFF : hint_count[7:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_make_hint_stream.sv
// Self-checking bench for make_hint_stream: threshold vector table, full vectors, backpressure, abort, async reset.
module tb_make_hint_stream;

  localparam int unsigned N     = 256;
  localparam int unsigned K     = 6;
  localparam int unsigned OMEGA = 55;
  localparam int unsigned TOT   = N * K;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [31:0] s_a0 = '0;
  logic [3:0]         s_a1 = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               m_hint;
  logic [7:0]         m_idx;
  logic [2:0]         m_poly;
  logic               m_last;
  logic               done;
  logic [10:0]        hint_count;
  logic               reject;
`ifdef MAKE_HINT_POLYCNT_EN
  logic               pc_valid;
  logic [7:0]         pc_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  make_hint_stream #(.GAMMA2(261888), .N(N), .K(K), .OMEGA(OMEGA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_a0(s_a0), .s_a1(s_a1),
    .m_valid(m_valid), .m_ready(m_ready), .m_hint(m_hint), .m_idx(m_idx),
    .m_poly(m_poly), .m_last(m_last), .done(done),
    .hint_count(hint_count), .reject(reject)
`ifdef MAKE_HINT_POLYCNT_EN
    , .pc_valid(pc_valid), .pc_count(pc_count)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference hint, written as an in-range test rather than the three-term OR
  function automatic bit hint_ref(input logic signed [31:0] a0, input logic [3:0] a1);
    if (a0 >= -32'sd261887 && a0 <= 32'sd261888) return 1'b0;
    if (a0 == -32'sd261888) return (a1 != 4'd0);
    return 1'b1;
  endfunction

  function automatic bit is_hint(input int mode, input int j, input int nh);
    if (mode == 0) return (j % 27 == 0) && (j / 27 < nh);
    return (j == 0) || (j == 1) || (j == 2) || (j == 256) || (j == 257);
  endfunction

  // ---------------- output-stream scoreboard ----------------
  typedef struct packed {
    logic       hint;
    logic [7:0] idx;
    logic [2:0] poly;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   mi, mp, out_cnt, cum, pc_pulses, pc_val;
  bit   done_exp, stall_prev, pc_exp;
  logic sv_hint, sv_last;
  logic [7:0] sv_idx;
  logic [2:0] sv_poly;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || start) begin
      q.delete();
      mi = 0; mp = 0; out_cnt = 0; cum = 0; pc_pulses = 0;
      done_exp = 0; stall_prev = 0; pc_exp = 0;
    end else begin
      if (done || done_exp) chk("done_pulse", done, done_exp);
      done_exp = 0;
`ifdef MAKE_HINT_POLYCNT_EN
      if (pc_valid || pc_exp) begin
        chk("pc_valid", pc_valid, pc_exp);
        if (pc_exp) chk("pc_count", pc_count, (pc_val > 255) ? 255 : pc_val);
      end
      if (pc_valid) pc_pulses++;
`endif
      pc_exp = 0;
      if (stall_prev && m_valid) begin
        chk("stall_hint", m_hint, sv_hint);
        chk("stall_idx", m_idx, sv_idx);
        chk("stall_poly", m_poly, sv_poly);
        chk("stall_last", m_last, sv_last);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_hint", m_hint, e.hint);
          chk("m_idx", m_idx, e.idx);
          chk("m_poly", m_poly, e.poly);
          chk("m_last", m_last, e.last);
          out_cnt++;
          cum += int'(e.hint);
          if (e.last) done_exp = 1;
          if (e.idx == 8'(N - 1)) begin
            pc_exp = 1;
            pc_val = cum;
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      sv_hint = m_hint; sv_idx = m_idx; sv_poly = m_poly; sv_last = m_last;
      if (stall_prev) chk("s_ready_stall", s_ready, 0);
      if (s_valid && s_ready) begin
        e.hint = hint_ref(s_a0, s_a1);
        e.idx  = 8'(mi);
        e.poly = 3'(mp);
        e.last = (mi == N - 1) && (mp == K - 1);
        q.push_back(e);
        if (mi == N - 1) begin mi = 0; mp++; end
        else mi++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_one(input logic signed [31:0] a0, input logic [3:0] a1);
    int  b;
    bit  hs;
    b = 0;
    s_valid = 1'b1; s_a0 = a0; s_a1 = a1;
    do begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      b++;
    end while (!hs && b < 100);
    if (!hs) chk("s_ready_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic feed(input int mode, input int nh, input int count, input bit stall);
    logic signed [31:0] a0;
    for (int j = 0; j < count; j++) begin
      a0 = is_hint(mode, j, nh) ? 32'sd300000 : 32'sd0;
      if (stall && j == 300) begin
        s_valid = 1'b1; s_a0 = a0; s_a1 = 4'(j);
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_s_ready", s_ready, 0);
          chk("bp_m_valid", m_valid, 1);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
      send_one(a0, 4'(j));
    end
  endtask

  task automatic wait_done(input int exp_cnt, input bit exp_rej);
    int b;
    @(negedge clk);
    chk("reject_before_done", reject, 0);
    chk("done_early", done, 0);
    b = 0;
    while (!done && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("hint_count", hint_count, exp_cnt);
      chk("reject", reject, exp_rej);
      chk("out_count", out_cnt, TOT);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("hint_count_held", hint_count, exp_cnt);
      chk("reject_held", reject, exp_rej);
    end
  endtask

  typedef struct {
    logic signed [31:0] a0;
    logic [3:0]         a1;
    logic               hint;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{32'sd261888,  4'd0,  1'b0};
    tbl[1] = '{32'sd261889,  4'd0,  1'b1};
    tbl[2] = '{-32'sd261889, 4'd0,  1'b1};
    tbl[3] = '{-32'sd261888, 4'd0,  1'b0};
    tbl[4] = '{-32'sd261888, 4'd5,  1'b1};
    tbl[5] = '{-32'sd261887, 4'd5,  1'b0};
    tbl[6] = '{32'sd0,       4'd15, 1'b0};
    tbl[7] = '{32'sh7fffffff, 4'd0, 1'b1};
    tbl[8] = '{32'sh80000000, 4'd0, 1'b1};
    tbl[9] = '{-32'sd261888, 4'd1,  1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_hint", m_hint, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_poly", m_poly, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_hint_count", hint_count, 0);
    chk("rst_reject", reject, 0);
    chk("rst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 0);

    // Threshold table: each entry is the first coefficient of a fresh vector
    for (int i = 0; i < 10; i++) begin
      pulse_start();
      send_one(tbl[i].a0, tbl[i].a1);
      @(negedge clk);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, 1);
      chk($sformatf("tbl%0d_m_hint", i), m_hint, tbl[i].hint);
      chk($sformatf("tbl%0d_m_idx", i), m_idx, 0);
      chk($sformatf("tbl%0d_count", i), hint_count, int'(tbl[i].hint));
    end

    // Full vector at the OMEGA limit, then one over with backpressure
    pulse_start();
    feed(0, 55, TOT, 1'b0);
    wait_done(55, 1'b0);
    pulse_start();
    feed(0, 56, TOT, 1'b1);
    wait_done(56, 1'b1);

    // Abort after 100 coefficients; start collides with an offered hint coefficient
    pulse_start();
    feed(0, 55, 100, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b1; s_a0 = 32'sd300000; s_a1 = 4'd0;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("abort_hint_count", hint_count, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_reject", reject, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #1;
    feed(0, 55, TOT, 1'b0);
    wait_done(55, 1'b0);

    // Async reset mid-RUN
    pulse_start();
    feed(0, 20, 50, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_idx", m_idx, 0);
    chk("arst_m_poly", m_poly, 0);
    chk("arst_hint_count", hint_count, 0);
    chk("arst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b1; s_a0 = 32'sd300000;
    repeat (3) begin
      @(negedge clk);
      chk("arst_s_ready_after", s_ready, 0);
      chk("arst_m_valid_after", m_valid, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    pulse_start();
    feed(0, 10, TOT, 1'b0);
    wait_done(10, 1'b0);

`ifdef MAKE_HINT_POLYCNT_EN
    // Per-polynomial counts: 3 hints in poly 0, 2 in poly 1
    pulse_start();
    feed(1, 0, TOT, 1'b0);
    wait_done(5, 1'b0);
    chk("pc_count_final", pc_count, 5);
    chk("pc_pulses", pc_pulses, K);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
